// File: rtl/fifo_traffic_if.sv
// FIFO-side handshake bundle for fifo_traffic_ctrl.
// The controller owns the strobes and write data; the FIFO owns occupancy and flags.
interface fifo_traffic_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] fifo_data;
  logic [CNT_W-1:0]  fifo_words;
  logic              fifo_full;
  logic              fifo_empty;

  modport master (
    output wr_en,
    output rd_en,
    output fifo_data,
    input  fifo_words,
    input  fifo_full,
    input  fifo_empty
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  fifo_data,
    output fifo_words,
    output fifo_full,
    output fifo_empty
  );
endinterface

// File: rtl/fifo_traffic_ctrl.sv
// Hysteresis traffic generator for a FIFO under test: fills to HIGH_MARK, drains to
// LOW_MARK, emits a mode-selected data pattern and counts DRAIN->FILL round trips.
module fifo_traffic_ctrl #(
  parameter int                DATA_W    = 8,
  parameter int                CNT_W     = 4,
  parameter int                HIGH_MARK = 5,
  parameter int                LOW_MARK  = 2,
  parameter logic [DATA_W-1:0] PATTERN   = 8'hAA,
  parameter int                RT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      mode,
  fifo_traffic_if.master  fifo,
  output logic [1:0]      state,
  output logic [RT_W-1:0] round_trips
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] HIGH_C = CNT_W'(HIGH_MARK);
  localparam logic [CNT_W-1:0] LOW_C  = CNT_W'(LOW_MARK);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] data_nxt_s;
  logic [RT_W-1:0]   rt_r;
  logic              rt_inc_s;
  logic              load_pat_s;
  logic              wr_s;
  logic              rd_s;
  logic              hit_high_s;
  logic              hit_low_s;

  // Strobes gated by the flags; threshold decodes (a flag alone also turns the loop around)
  always_comb begin
    wr_s       = (state_r == ST_FILL)  & ~fifo.fifo_full;
    rd_s       = (state_r == ST_DRAIN) & ~fifo.fifo_empty;
    hit_high_s = (fifo.fifo_words >= HIGH_C) | fifo.fifo_full;
    hit_low_s  = (fifo.fifo_words <= LOW_C)  | fifo.fifo_empty;
  end

  // Next-state decode; en=0 outranks any threshold hit
  always_comb begin
    state_nxt_s = state_r;
    rt_inc_s    = 1'b0;
    load_pat_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_nxt_s = ST_FILL;
          load_pat_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (!en) begin
          state_nxt_s = ST_IDLE;
        end else if (hit_high_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (!en) begin
          state_nxt_s = ST_IDLE;
        end else if (hit_low_s) begin
          state_nxt_s = ST_FILL;
          rt_inc_s    = 1'b1;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Write data advances only on an accepted write; a run start reloads the base word
  always_comb begin
    data_nxt_s = data_r;
    if (load_pat_s) begin
      data_nxt_s = PATTERN;
    end else if (wr_s) begin
      case (mode)
        2'b00:   data_nxt_s = PATTERN;
        2'b01:   data_nxt_s = data_r + DATA_W'(1'b1);
        2'b10:   data_nxt_s = ~data_r;
        default: data_nxt_s = PATTERN;
      endcase
    end else begin
      data_nxt_s = data_r;
    end
  end

  // State, data and round-trip registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      data_r  <= PATTERN;
      rt_r    <= {RT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      data_r  <= data_nxt_s;
      rt_r    <= rt_r + RT_W'(rt_inc_s);
    end
  end

  assign fifo.wr_en     = wr_s;
  assign fifo.rd_en     = rd_s;
  assign fifo.fifo_data = data_r;
  assign state          = state_r;
  assign round_trips    = rt_r;

endmodule

// File: tb/tb_fifo_traffic_ctrl.sv
// Self-checking bench for fifo_traffic_ctrl: a hand-computed vector table plus
// FIFO-model driven runs on two parameterisations, checked through a scoreboard queue.
module tb_fifo_traffic_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [1:0]  state_a;
  logic [1:0]  state_b;
  logic [15:0] rt_a;
  logic [15:0] rt_b;

  always #5 clk = ~clk;

  fifo_traffic_if #(.DATA_W(8), .CNT_W(4)) ifa ();
  fifo_traffic_if #(.DATA_W(8), .CNT_W(5)) ifb ();

  fifo_traffic_ctrl #(.DATA_W(8), .CNT_W(4), .HIGH_MARK(5), .LOW_MARK(2),
                      .PATTERN(8'hAA), .RT_W(16)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .fifo(ifa.master),
    .state(state_a), .round_trips(rt_a));

  fifo_traffic_ctrl #(.DATA_W(8), .CNT_W(5), .HIGH_MARK(12), .LOW_MARK(4),
                      .PATTERN(8'hFF), .RT_W(16)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .fifo(ifb.master),
    .state(state_b), .round_trips(rt_b));

  // inputs {r,e,md,w,f,em} and expected post-edge outputs {st,wr,rd,d,rt}
  typedef struct {
    logic r; logic e; logic [1:0] md; logic [4:0] w; logic f; logic em;
    logic [1:0] st; logic wr; logic rd; logic [7:0] d; logic [15:0] rt;
  } row_t;

  typedef struct {
    int dut; logic [1:0] st; logic wr; logic rd; logic [7:0] d; logic [15:0] rt; string tag;
  } exp_t;

  localparam int NROWS = 29;
  row_t tab [NROWS];
  exp_t sb [$];

  int checks = 0;
  int errors = 0;
  int m_st [2];
  int m_d  [2];
  int m_rt [2];
  int cnt  [2];
  int depth [2] = '{8, 20};
  int hi    [2] = '{5, 12};
  int lo    [2] = '{2, 4};
  int pat   [2] = '{'hAA, 'hFF};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic get_out(input int i, output logic [1:0] st, output logic wr, output logic rd,
                         output logic [7:0] d, output logic [15:0] rt);
    if (i == 0) begin
      st = state_a; wr = ifa.wr_en; rd = ifa.rd_en; d = ifa.fifo_data; rt = rt_a;
    end else begin
      st = state_b; wr = ifb.wr_en; rd = ifb.rd_en; d = ifb.fifo_data; rt = rt_b;
    end
  endtask

  // reference behaviour of one controller for one clock edge
  function automatic void mstep(input int i, input logic r, input logic e, input logic [1:0] md,
                                input int w, input logic f, input logic em, input logic wr,
                                output int ns, output int nd, output int nrt);
    ns = m_st[i]; nd = m_d[i]; nrt = m_rt[i];
    if (r) begin
      ns = 0; nd = pat[i]; nrt = 0;
    end else begin
      case (m_st[i])
        0: if (e) begin ns = 1; nd = pat[i]; end
        1: if (!e) ns = 0; else if (w >= hi[i] || f) ns = 2;
        2: if (!e) ns = 0; else if (w <= lo[i] || em) begin ns = 1; nrt = (m_rt[i] + 1) % 65536; end
        default: ns = 0;
      endcase
      if (wr) begin
        case (md)
          2'b01:   nd = (m_d[i] + 1) % 256;
          2'b10:   nd = (~m_d[i]) & 255;
          default: nd = pat[i];
        endcase
      end
    end
  endfunction

  // one clock: drive at negedge, check strobes, push expectations, pop after the edge
  task automatic cycle(input logic r, input logic e, input logic [1:0] md,
                       input bit tab_on, input row_t row);
    int w [2]; logic f [2]; logic em [2]; logic mwr [2]; logic mrd [2];
    int ns [2]; int nd [2]; int nrt [2];
    logic [1:0] ost; logic owr; logic ord; logic [7:0] od; logic [15:0] ort;
    exp_t x;
    rst = r; en = e; mode = md;
    for (int i = 0; i < 2; i++) begin
      w[i] = cnt[i]; f[i] = (cnt[i] == depth[i]); em[i] = (cnt[i] == 0);
    end
    if (tab_on) begin
      w[0] = int'(row.w); f[0] = row.f; em[0] = row.em;
    end
    ifa.fifo_words = 4'(w[0]); ifa.fifo_full = f[0]; ifa.fifo_empty = em[0];
    ifb.fifo_words = 5'(w[1]); ifb.fifo_full = f[1]; ifb.fifo_empty = em[1];
    #1;
    for (int i = 0; i < 2; i++) begin
      mwr[i] = (m_st[i] == 1) && !f[i];
      mrd[i] = (m_st[i] == 2) && !em[i];
      get_out(i, ost, owr, ord, od, ort);
      chk($sformatf("wr_en_pre%0d", i), 32'(owr), 32'(mwr[i]));
      chk($sformatf("rd_en_pre%0d", i), 32'(ord), 32'(mrd[i]));
      mstep(i, r, e, md, w[i], f[i], em[i], mwr[i], ns[i], nd[i], nrt[i]);
      x = '{i, 2'(ns[i]), (ns[i] == 1) && !f[i], (ns[i] == 2) && !em[i], 8'(nd[i]), 16'(nrt[i]), "model"};
      sb.push_back(x);
    end
    if (tab_on) begin
      x = '{0, row.st, row.wr, row.rd, row.d, row.rt, "table"};
      sb.push_back(x);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!(tab_on && i == 0)) begin
        if (mwr[i]) cnt[i]++;
        if (mrd[i]) cnt[i]--;
      end
      m_st[i] = ns[i]; m_d[i] = nd[i]; m_rt[i] = nrt[i];
    end
    @(negedge clk);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      get_out(x.dut, ost, owr, ord, od, ort);
      chk($sformatf("%s%0d_state", x.tag, x.dut), 32'(ost), 32'(x.st));
      chk($sformatf("%s%0d_wr_en", x.tag, x.dut), 32'(owr), 32'(x.wr));
      chk($sformatf("%s%0d_rd_en", x.tag, x.dut), 32'(ord), 32'(x.rd));
      chk($sformatf("%s%0d_data", x.tag, x.dut), 32'(od), 32'(x.d));
      chk($sformatf("%s%0d_round_trips", x.tag, x.dut), 32'(ort), 32'(x.rt));
    end
  endtask

  initial begin
    row_t nr;
    nr = '{1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 16'd0};
    // reset, mode 00 fill ramp to HIGH_MARK, drain to LOW_MARK
    tab[0]  = '{1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'hAA, 16'd0};
    tab[1]  = '{1'b1, 1'b1, 2'd1, 5'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'hAA, 16'd0};
    tab[2]  = '{1'b0, 1'b1, 2'd0, 5'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'hAA, 16'd0};
    tab[3]  = '{1'b0, 1'b1, 2'd0, 5'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'hAA, 16'd0};
    tab[4]  = '{1'b0, 1'b1, 2'd0, 5'd1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'hAA, 16'd0};
    tab[5]  = '{1'b0, 1'b1, 2'd0, 5'd2, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'hAA, 16'd0};
    tab[6]  = '{1'b0, 1'b1, 2'd0, 5'd3, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'hAA, 16'd0};
    tab[7]  = '{1'b0, 1'b1, 2'd0, 5'd4, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'hAA, 16'd0};
    tab[8]  = '{1'b0, 1'b1, 2'd0, 5'd5, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 8'hAA, 16'd0};
    tab[9]  = '{1'b0, 1'b1, 2'd0, 5'd5, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 8'hAA, 16'd0};
    tab[10] = '{1'b0, 1'b1, 2'd0, 5'd4, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 8'hAA, 16'd0};
    tab[11] = '{1'b0, 1'b1, 2'd0, 5'd3, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 8'hAA, 16'd0};
    tab[12] = '{1'b0, 1'b1, 2'd0, 5'd2, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'hAA, 16'd1};
    // mode 01 increments, full flag in FILL, both flags high in DRAIN and FILL
    tab[13] = '{1'b0, 1'b1, 2'd1, 5'd2, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'hAB, 16'd1};
    tab[14] = '{1'b0, 1'b1, 2'd1, 5'd3, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'hAC, 16'd1};
    tab[15] = '{1'b0, 1'b1, 2'd2, 5'd3, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 8'hAC, 16'd1};
    tab[16] = '{1'b0, 1'b1, 2'd0, 5'd3, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 8'hAC, 16'd2};
    tab[17] = '{1'b0, 1'b1, 2'd0, 5'd3, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 8'hAC, 16'd2};
    // en drop on a LOW_MARK hit, then mode 10 alternation from a fresh start
    tab[18] = '{1'b0, 1'b0, 2'd0, 5'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'hAC, 16'd2};
    tab[19] = '{1'b0, 1'b0, 2'd2, 5'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'hAC, 16'd2};
    tab[20] = '{1'b0, 1'b1, 2'd2, 5'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'hAA, 16'd2};
    tab[21] = '{1'b0, 1'b1, 2'd2, 5'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'h55, 16'd2};
    tab[22] = '{1'b0, 1'b1, 2'd2, 5'd1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'hAA, 16'd2};
    tab[23] = '{1'b0, 1'b1, 2'd2, 5'd2, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'h55, 16'd2};
    tab[24] = '{1'b0, 1'b0, 2'd2, 5'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'hAA, 16'd2};
    // reset mid-DRAIN clears counter and data
    tab[25] = '{1'b0, 1'b1, 2'd1, 5'd3, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'hAA, 16'd2};
    tab[26] = '{1'b0, 1'b1, 2'd1, 5'd5, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 8'hAB, 16'd2};
    tab[27] = '{1'b1, 1'b1, 2'd1, 5'd4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'hAA, 16'd0};
    tab[28] = '{1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'hAA, 16'd0};

    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; m_st[i] = 0; m_d[i] = pat[i]; m_rt[i] = 0;
    end
    rst = 1'b1; en = 1'b0; mode = 2'd0;
    ifa.fifo_words = 4'd0; ifa.fifo_full = 1'b0; ifa.fifo_empty = 1'b1;
    ifb.fifo_words = 5'd0; ifb.fifo_full = 1'b0; ifb.fifo_empty = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // mode 01 from reset: second word wraps FF->00 on the PATTERN=FF instance
    cycle(1'b0, 1'b1, 2'd1, 1'b0, nr);
    cycle(1'b0, 1'b1, 2'd1, 1'b0, nr);
    chk("wrap_b_data", 32'(ifb.fifo_data), 32'h00);
    chk("incr_a_data", 32'(ifa.fifo_data), 32'hAB);

    for (int k = 0; k < NROWS; k++) cycle(tab[k].r, tab[k].e, tab[k].md, 1'b1, tab[k]);

    // FIFO-model loops on both instances in each pattern mode
    for (int k = 0; k < 150; k++) cycle(1'b0, 1'b1, 2'd0, 1'b0, nr);
    for (int k = 0; k < 100; k++) cycle(1'b0, 1'b1, 2'd1, 1'b0, nr);
    for (int k = 0; k < 4; k++)   cycle(1'b0, 1'b0, 2'd1, 1'b0, nr);
    for (int k = 0; k < 100; k++) cycle(1'b0, 1'b1, 2'd2, 1'b0, nr);
    chk("rt_a_nonzero", 32'(rt_a != 16'd0), 32'd1);

    // randomised en/mode/reset traffic
    for (int k = 0; k < 500; k++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0),
            2'($urandom_range(0, 3)), 1'b0, nr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
